// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU between two requesters
module alu_arbiter #(
  parameter int ALU_WAIT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [7:0] result,
  output logic       busy,
  output logic [7:0] op_count,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result
);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_n;
  logic rr, id, any, win, illegal;
  logic [2:0] win_op;
  logic [3:0] cnt;
  assign any = req0 | req1;
  assign win = (req0 & req1) ? rr : req1;
  assign win_op = win ? op1 : op0;
  assign illegal = win_op[2] & win_op[1];
  assign busy = state == EXEC;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? ((any && !illegal) ? EXEC : IDLE) : ((cnt == 4'd0) ? IDLE : EXEC);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      {gnt0, gnt1, done0, done1, err, rr, id} <= '0;
      result <= '0;
      op_count <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      {gnt0, gnt1, done0, done1, err} <= '0;
      if (state == IDLE && any) begin
        alu_a <= win ? a1 : a0;
        alu_b <= win ? b1 : b0;
        alu_op <= win_op;
        id <= win;
        rr <= ~win;
        gnt0 <= ~win;
        gnt1 <= win;
        // illegal opcodes complete in the grant cycle without touching the ALU
        if (illegal) begin
          done0 <= ~win;
          done1 <= win;
          err <= 1'b1;
          result <= '0;
          op_count <= op_count + 8'd1;
        end else begin
          cnt <= 4'(ALU_WAIT - 1);
        end
      end else if (state == EXEC) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          result <= alu_result;
          done0 <= ~id;
          done1 <= id;
          op_count <= op_count + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter (ALU_WAIT=1 and ALU_WAIT=4 instances)
module tb_alu_arbiter;
  logic clk = 0, resetn = 0, req0 = 0, req1 = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [2:0] op0 = 0, op1 = 0;
  logic gnt0, gnt1, done0, done1, err, busy;
  logic [7:0] result, op_count, alu_result;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic gnt0_4, gnt1_4, done0_4, done1_4, err_4, busy_4;
  logic [7:0] result_4, op_count_4;
  logic [7:0] alu_res4 = 0;
  logic [3:0] alu_a_4, alu_b_4;
  logic [2:0] alu_op_4;
  int total = 0, bad = 0;
  bit mon_en = 0;
  logic [9:0] sb[$];
  logic [9:0] mon_e;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    case (op)
      3'd0: return {a, b};
      3'd1: return {3'b0, {1'b0, a} + {1'b0, b}};
      3'd2: return 8'(a) + 8'(b);
      3'd3: return {a | b, a ^ b};
      3'd4: return {7'b0, |{a, b}};
      3'd5: return {7'b0, (^a) & (^b)};
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  alu_arbiter #(.ALU_WAIT(1)) dut1 (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .result(result), .busy(busy), .op_count(op_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  alu_arbiter #(.ALU_WAIT(4)) dut4 (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .gnt0(gnt0_4), .gnt1(gnt1_4), .done0(done0_4), .done1(done1_4), .err(err_4),
    .result(result_4), .busy(busy_4), .op_count(op_count_4),
    .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_op(alu_op_4), .alu_result(alu_res4)
  );

  // scoreboard consumer for the ALU_WAIT=1 instance: {id, err, result}
  always @(negedge clk) begin
    if (mon_en && (done0 || done1)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got id=%0d err=%0b result=%h, expected nothing", done1, err, result);
      end else begin
        mon_e = sb.pop_front();
        if ({done1, err, result} !== mon_e || (done0 & done1)) begin
          bad++;
          $display("FAIL sb_done: got id=%0d err=%0b result=%h done0=%0b done1=%0b, expected id=%0d err=%0b result=%h",
                   done1, err, result, done0, done1, mon_e[9], mon_e[8], mon_e[7:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    mon_en = 0;
    resetn = 0;
    req0 = 0;
    req1 = 0;
    sb.delete();
    repeat (2) step();
    resetn = 1;
    mon_en = 1;
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n && sb.size() != 0; i++) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results still pending after %0d cycles, expected 0", sb.size(), n);
    end
  endtask

  task automatic test_reset;
    mon_en = 0;
    sb.delete();
    resetn = 0;
    req0 = 1; a0 = 4'h1; b0 = 4'h2; op0 = 3'd2;
    repeat (3) begin
      step();
      total++;
      if ({gnt0, gnt1, done0, done1, err, busy, result, op_count, alu_a, alu_b, alu_op,
           gnt0_4, busy_4, op_count_4} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: gnt=%0b%0b done=%0b%0b err=%0b busy=%0b result=%h cnt=%h alu=%h/%h/%h, expected all 0",
                 gnt0, gnt1, done0, done1, err, busy, result, op_count, alu_a, alu_b, alu_op);
      end
    end
    resetn = 1;
    mon_en = 1;
    sb.push_back({1'b0, 1'b0, 8'h03});
    step();
    total++;
    if (gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_gnt: gnt0=%0b, expected 1", gnt0);
    end
    req0 = 0;
    drain(10);
  endtask

  task automatic test_single;
    do_reset();
    req0 = 1; a0 = 4'hA; b0 = 4'h7; op0 = 3'd2;
    sb.push_back({1'b0, 1'b0, 8'h11});
    step();
    total++;
    if (gnt0 !== 1'b1 || alu_a !== 4'hA || alu_b !== 4'h7 || alu_op !== 3'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_gnt: gnt0=%0b alu=%h/%h/%h busy=%0b, expected 1 A/7/2 1", gnt0, alu_a, alu_b, alu_op, busy);
    end
    req0 = 0;
    step();
    total++;
    if (done0 !== 1'b1 || result !== 8'h11 || err !== 1'b0 || op_count !== 8'd1) begin
      bad++;
      $display("FAIL single_done: done0=%0b result=%h err=%0b op_count=%0d, expected 1 11 0 1", done0, result, err, op_count);
    end
    drain(5);
  endtask

  task automatic test_simultaneous;
    int order[$];
    do_reset();
    a0 = 4'h3; b0 = 4'hC; op0 = 3'd0;
    a1 = 4'h5; b1 = 4'h3; op1 = 3'd3;
    req0 = 1; req1 = 1;
    sb.push_back({1'b0, 1'b0, 8'h3C});
    sb.push_back({1'b1, 1'b0, 8'h76});
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt0) begin order.push_back(0); req0 = 0; end
      if (gnt1) begin order.push_back(1); req1 = 0; end
      if (order.size() == 2 && sb.size() == 0) break;
    end
    total++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
      bad++;
      $display("FAIL simul_order: %0d grants, first=%0d, expected 2 grants order 0,1",
               order.size(), order.size() > 0 ? order[0] : -1);
    end
    total++;
    if (dut1.rr !== 1'b0 || result !== 8'h76) begin
      bad++;
      $display("FAIL simul_rr: rr=%0b result=%h, expected rr=0 result=76", dut1.rr, result);
    end
    drain(5);
  endtask

  task automatic test_fairness;
    int prev = -1, n = 0;
    bit id;
    do_reset();
    a0 = 4'h2; b0 = 4'h3; op0 = 3'd2;
    a1 = 4'h9; b1 = 4'h4; op1 = 3'd3;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 60 && n < 8; i++) begin
      step();
      if (gnt0 || gnt1) begin
        id = gnt1;
        sb.push_back(id ? {1'b1, 1'b0, 8'hDD} : {1'b0, 1'b0, 8'h05});
        total++;
        if (int'(id) == prev || (n == 0 && id) || (gnt0 & gnt1)) begin
          bad++;
          $display("FAIL fair_alternate: grant %0d to %0d (gnt0=%0b gnt1=%0b), previous %0d", n, id, gnt0, gnt1, prev);
        end
        prev = int'(id);
        n++;
      end
    end
    req0 = 0; req1 = 0;
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL fair_count: %0d grants seen, expected 8", n);
    end
    drain(10);
  endtask

  task automatic test_illegal;
    bit rose = 0;
    do_reset();
    req1 = 1; a1 = 4'h5; b1 = 4'h5; op1 = 3'd7;
    sb.push_back({1'b1, 1'b1, 8'h00});
    step();
    total++;
    if (gnt1 !== 1'b1 || done1 !== 1'b1 || err !== 1'b1 || result !== 8'h00 || busy !== 1'b0 || op_count !== 8'd1) begin
      bad++;
      $display("FAIL illegal_op7: gnt1=%0b done1=%0b err=%0b result=%h busy=%0b op_count=%0d, expected 1 1 1 00 0 1",
               gnt1, done1, err, result, busy, op_count);
    end
    req1 = 0;
    repeat (3) begin step(); if (busy) rose = 1; end
    total++;
    if (rose) begin
      bad++;
      $display("FAIL illegal_busy: busy=1 seen, expected 0");
    end
    req0 = 1; a0 = 4'h1; b0 = 4'h1; op0 = 3'd6;
    sb.push_back({1'b0, 1'b1, 8'h00});
    step();
    total++;
    if (gnt0 !== 1'b1 || done0 !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || op_count !== 8'd2) begin
      bad++;
      $display("FAIL illegal_op6: gnt0=%0b done0=%0b err=%0b busy=%0b op_count=%0d, expected 1 1 1 0 2",
               gnt0, done0, err, busy, op_count);
    end
    req0 = 0;
    drain(5);
  endtask

  task automatic test_wrap;
    do_reset();
    for (int k = 0; k < 256; k++) begin
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'(k % 6);
      sb.push_back({1'b0, 1'b0, alu_f(a0, b0, op0)});
      req0 = 1;
      step();
      for (int j = 0; j < 5 && !gnt0; j++) step();
      if (!gnt0) begin
        total++; bad++;
        $display("FAIL wrap_gnt: op %0d gnt0=0, expected 1", k);
      end
      req0 = 0;
      drain(10);
      if (k == 254) begin
        total++;
        if (op_count !== 8'hFF) begin
          bad++;
          $display("FAIL wrap_ff: op_count=%h, expected ff", op_count);
        end
      end
    end
    total++;
    if (op_count !== 8'h00) begin
      bad++;
      $display("FAIL wrap_zero: op_count=%h, expected 00", op_count);
    end
  endtask

  task automatic test_wait4;
    do_reset();
    mon_en = 0;
    req0 = 1; a0 = 4'h1; b0 = 4'h2; op0 = 3'd2;
    alu_res4 = 8'hA0;
    for (int k = 1; k <= 5; k++) begin
      step();
      alu_res4 = 8'hA0 + 8'(k);
      if (k == 1) req0 = 0;
      total++;
      if (k < 5 && (busy_4 !== 1'b1 || done0_4 !== 1'b0 || gnt0_4 !== (k == 1))) begin
        bad++;
        $display("FAIL wait4_exec: cycle %0d busy=%0b done0=%0b gnt0=%0b, expected 1 0 %0b", k, busy_4, done0_4, gnt0_4, k == 1);
      end else if (k == 5 && (done0_4 !== 1'b1 || result_4 !== 8'hA4 || err_4 !== 1'b0 || busy_4 !== 1'b0)) begin
        bad++;
        $display("FAIL wait4_done: done0=%0b result=%h err=%0b busy=%0b, expected 1 a4 0 0", done0_4, result_4, err_4, busy_4);
      end
    end
  endtask

  task automatic test_abort;
    bit saw = 0;
    do_reset();
    mon_en = 0;
    req0 = 1; a0 = 4'h6; b0 = 4'h6; op0 = 3'd2;
    step();
    req0 = 0;
    step();
    resetn = 0;
    #1;
    total++;
    if ({busy_4, gnt0_4, done0_4, op_count_4, alu_a_4, result_4} !== '0) begin
      bad++;
      $display("FAIL abort_clear: busy=%0b gnt0=%0b done0=%0b op_count=%0d alu_a=%h result=%h, expected all 0",
               busy_4, gnt0_4, done0_4, op_count_4, alu_a_4, result_4);
    end
    repeat (2) step();
    resetn = 1;
    repeat (8) begin step(); if (done0_4 || done1_4) saw = 1; end
    total++;
    if (saw) begin
      bad++;
      $display("FAIL abort_done: done pulse seen after aborted op, expected none");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_illegal();
    test_wrap();
    test_wait4();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
